// File: rtl/fp_result_export_pipe.sv
// Special-value fixup stage for sqrt/square/pass results, followed by a
// 2-entry in-order output buffer with an accumulated invalid-operation flag.
module fp_result_export_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] temp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid,
  output logic         sticky_invalid,
  input  logic         sticky_clr
);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
  localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] PZERO = '0;

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic             is_zero;
  logic             is_inf;
  logic             is_nan;

  logic [W-1:0]     new_res;
  logic             new_flag;

  logic [1:0]       count;
  logic [W-1:0]     head_res;
  logic             head_flag;
  logic [W-1:0]     tail_res;
  logic             tail_flag;

  logic             push;
  logic             pop;

  assign in_sign = in1[W-1];
  assign in_exp  = in1[W-2:MAN_W];
  assign in_man  = in1[MAN_W-1:0];

  assign is_zero = (in_exp == '0) && (in_man == '0);
  assign is_inf  = (&in_exp) && (in_man == '0);
  assign is_nan  = (&in_exp) && (in_man != '0);

  // NaN input always wins; only sqrt of a nonzero negative raises invalid.
  always_comb begin
    new_res  = temp_result;
    new_flag = 1'b0;
    unique case (op)
      2'b00: begin
        if (is_nan) begin
          new_res = QNAN;
        end else if (in_sign && !is_zero) begin
          new_res  = QNAN;
          new_flag = 1'b1;
        end else if (is_zero) begin
          new_res = in1;
        end else if (is_inf) begin
          new_res = PINF;
        end
      end
      2'b01: begin
        if (is_nan) begin
          new_res = QNAN;
        end else if (is_inf) begin
          new_res = PINF;
        end else if (is_zero) begin
          new_res = PZERO;
        end
      end
      default: begin
        if (is_nan) begin
          new_res = QNAN;
        end
      end
    endcase
  end

  assign in_ready       = !rst && (count != 2'd2);
  assign out_valid      = (count != 2'd0);
  assign result         = head_res;
  assign flag_invalid   = head_flag;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head register doubles as the output; it is left untouched on the final
  // pop so the last result stays visible while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= 2'd0;
      head_res       <= '0;
      head_flag      <= 1'b0;
      tail_res       <= '0;
      tail_flag      <= 1'b0;
      sticky_invalid <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_res  <= new_res;
            head_flag <= new_flag;
            count     <= 2'd1;
          end else begin
            tail_res  <= new_res;
            tail_flag <= new_flag;
            count     <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_res  <= tail_res;
            head_flag <= tail_flag;
            count     <= 2'd1;
          end else begin
            count     <= 2'd0;
          end
        end
        2'b11: begin
          head_res  <= new_res;
          head_flag <= new_flag;
        end
        default: begin
        end
      endcase

      if (push && new_flag) begin
        sticky_invalid <= 1'b1;
      end else if (sticky_clr) begin
        sticky_invalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_result_export_pipe.sv
// Directed bench for fp_result_export_pipe: specials, handshake/backpressure,
// sticky flag, reset behaviour and a double-precision build.
module tb_fp_result_export_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] temp_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid;
  logic        sticky_invalid;
  logic        sticky_clr;

  logic        in_valid64;
  logic        in_ready64;
  logic [1:0]  op64;
  logic [63:0] in1_64;
  logic [63:0] temp64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] result64;
  logic        flag64;
  logic        sticky64;
  logic        sticky_clr64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_result_export_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .temp_result(temp_result), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_invalid(flag_invalid),
    .sticky_invalid(sticky_invalid), .sticky_clr(sticky_clr)
  );

  fp_result_export_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
    .in1(in1_64), .temp_result(temp64), .out_valid(out_valid64),
    .out_ready(out_ready64), .result(result64), .flag_invalid(flag64),
    .sticky_invalid(sticky64), .sticky_clr(sticky_clr64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] t);
    in_valid    = 1'b1;
    op          = o;
    in1         = a;
    temp_result = t;
    stepCycle();
    in_valid    = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] res,
                           input logic flag);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_res"}, {32'd0, result}, {32'd0, res});
    checkOutput({tag, "_flag"}, {63'd0, flag_invalid}, {63'd0, flag});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; in1 = '0; temp_result = '0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    in_valid64 = 1'b0; op64 = 2'b00; in1_64 = '0; temp64 = '0;
    out_ready64 = 1'b1; sticky_clr64 = 1'b0;

    stepCycle();
    stepCycle();
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_result", {32'd0, result}, 64'd0);
    checkOutput("rst_flag", {63'd0, flag_invalid}, 64'd0);
    checkOutput("rst_sticky", {63'd0, sticky_invalid}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Double-precision build: sqrt(-1.0) is invalid.
    in_valid64 = 1'b1; op64 = 2'b00; in1_64 = 64'hBFF0000000000000;
    temp64 = 64'h0123456789ABCDEF;
    stepCycle();
    in_valid64 = 1'b0;
    checkOutput("dp_valid", {63'd0, out_valid64}, 64'd1);
    checkOutput("dp_res", result64, 64'h7FFFFFFFFFFFFFFF);
    checkOutput("dp_flag", {63'd0, flag64}, 64'd1);

    // Sqrt specials, streamed back to back with out_ready held high.
    applyStimulus(2'b00, 32'h00000000, 32'h11111111); checkBeat("sq_pz", 32'h00000000, 1'b0);
    applyStimulus(2'b00, 32'h80000000, 32'h11111111); checkBeat("sq_nz", 32'h80000000, 1'b0);
    applyStimulus(2'b00, 32'h7F800000, 32'h11111111); checkBeat("sq_pinf", 32'h7F800000, 1'b0);
    checkOutput("sticky_before_inv", {63'd0, sticky_invalid}, 64'd0);
    applyStimulus(2'b00, 32'hFF800000, 32'h11111111); checkBeat("sq_ninf", 32'h7FFFFFFF, 1'b1);
    checkOutput("sticky_after_inv", {63'd0, sticky_invalid}, 64'd1);
    applyStimulus(2'b00, 32'hBF800000, 32'h11111111); checkBeat("sq_neg1", 32'h7FFFFFFF, 1'b1);
    applyStimulus(2'b00, 32'h7FC00001, 32'h11111111); checkBeat("sq_nan", 32'h7FFFFFFF, 1'b0);
    applyStimulus(2'b00, 32'h40800000, 32'h40000000); checkBeat("sq_fin", 32'h40000000, 1'b0);

    // Square, pass and reserved op.
    applyStimulus(2'b01, 32'hFF800000, 32'h11111111); checkBeat("sqr_ninf", 32'h7F800000, 1'b0);
    applyStimulus(2'b01, 32'h80000000, 32'h11111111); checkBeat("sqr_nz", 32'h00000000, 1'b0);
    applyStimulus(2'b01, 32'h7F800001, 32'h11111111); checkBeat("sqr_nan", 32'h7FFFFFFF, 1'b0);
    applyStimulus(2'b01, 32'hC0000000, 32'h40800000); checkBeat("sqr_fin", 32'h40800000, 1'b0);
    applyStimulus(2'b10, 32'h40800000, 32'h12345678); checkBeat("pass", 32'h12345678, 1'b0);
    applyStimulus(2'b11, 32'hFFC00000, 32'h12345678); checkBeat("rsv_nan", 32'h7FFFFFFF, 1'b0);
    applyStimulus(2'b11, 32'hBF800000, 32'h55AA55AA); checkBeat("rsv_neg", 32'h55AA55AA, 1'b0);

    // Drain: buffer empty, last result held.
    stepCycle();
    checkOutput("drain_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("drain_hold", {32'd0, result}, 64'h55AA55AA);

    // Backpressure: two beats fit, the third is refused.
    out_ready = 1'b0;
    applyStimulus(2'b10, 32'h3F800000, 32'hA0000001);
    checkBeat("bp_a", 32'hA0000001, 1'b0);
    checkOutput("bp_rdy1", {63'd0, in_ready}, 64'd1);
    applyStimulus(2'b10, 32'h3F800000, 32'hA0000002);
    checkBeat("bp_a_hold", 32'hA0000001, 1'b0);
    checkOutput("bp_rdy2", {63'd0, in_ready}, 64'd0);
    applyStimulus(2'b10, 32'h3F800000, 32'hA0000003);
    checkBeat("bp_a_hold2", 32'hA0000001, 1'b0);
    checkOutput("bp_rdy3", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    stepCycle();
    checkBeat("bp_b", 32'hA0000002, 1'b0);
    checkOutput("bp_rdy_free", {63'd0, in_ready}, 64'd1);
    stepCycle();
    checkOutput("bp_empty", {63'd0, out_valid}, 64'd0);

    // Full throughput with in_valid held.
    in_valid = 1'b1; op = 2'b10; in1 = 32'h3F800000;
    for (int i = 0; i < 4; i++) begin
      temp_result = 32'hC0DE0000 + i;
      stepCycle();
      checkOutput("tp_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("tp_res", {32'd0, result}, {32'd0, 32'hC0DE0000 + i});
      checkOutput("tp_rdy", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    stepCycle();
    checkOutput("tp_empty", {63'd0, out_valid}, 64'd0);

    // Sticky: set and clear on the same edge keeps it set.
    sticky_clr = 1'b1;
    stepCycle();
    sticky_clr = 1'b0;
    checkOutput("st_clr0", {63'd0, sticky_invalid}, 64'd0);
    applyStimulus(2'b00, 32'hBF800000, 32'h0);
    checkOutput("st_set", {63'd0, sticky_invalid}, 64'd1);
    sticky_clr = 1'b1;
    applyStimulus(2'b00, 32'hC0800000, 32'h0);
    sticky_clr = 1'b0;
    checkOutput("st_both", {63'd0, sticky_invalid}, 64'd1);
    checkBeat("st_beat", 32'h7FFFFFFF, 1'b1);
    sticky_clr = 1'b1;
    stepCycle();
    sticky_clr = 1'b0;
    checkOutput("st_clr", {63'd0, sticky_invalid}, 64'd0);

    // Reset with two buffered beats discards them.
    out_ready = 1'b0;
    applyStimulus(2'b10, 32'h0, 32'hDEAD0001);
    applyStimulus(2'b10, 32'h0, 32'hDEAD0002);
    checkOutput("mr_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    stepCycle();
    checkOutput("mr_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mr_rdy", {63'd0, in_ready}, 64'd0);
    checkOutput("mr_res", {32'd0, result}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("mr_rdy_after", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("mr_no_stale", {63'd0, out_valid}, 64'd0);
    stepCycle();
    checkOutput("mr_no_stale2", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_result_export_pipe.md
FP_RESULT_EXPORT_PIPE -- requirements
Module: fp_result_export_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, mantissa field width; W = 1+EXP_W+MAN_W (32 at defaults).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- op  in  2  00 sqrt, 01 square, 10 pass, 11 reserved
- in1  in  W  original operand
- temp_result  in  W  datapath result
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- result  out  W  final result
- flag_invalid  out  1  invalid-operation flag for the current result beat
- sticky_invalid  out  1  accumulated invalid flag
- sticky_clr  in  1  clears sticky_invalid

Function
REQ-005 Classification of in1 SHALL be: zero = exp 0 and man 0 (either sign); inf = exp all-ones and man 0; NaN = exp all-ones and man nonzero; all else (including subnormals) is finite.
REQ-006 Canonical qNaN SHALL be {0, all-ones exp, all-ones man} (0x7FFFFFFF at defaults); +Inf SHALL be {0, all-ones exp, 0}.
REQ-007 In sqrt mode, priority SHALL be:
- NaN -> qNaN, invalid = 0.
- Nonzero with sign 1, including -Inf -> qNaN, invalid = 1.
- +0 -> +0; -0 -> -0 (sign preserved).
- +Inf -> +Inf.
- Otherwise -> temp_result.
REQ-008 In square mode:
- NaN -> qNaN.
- Inf of either sign -> +Inf.
- Zero of either sign -> +0.
- Otherwise -> temp_result.
- invalid = 0 in every case.
REQ-009 In pass mode and reserved op 11: NaN -> qNaN, else temp_result; invalid = 0.
REQ-010 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; op, in1 and temp_result are sampled only at acceptance.
REQ-011 Accepted beats SHALL go into a 2-entry in-order output buffer; in_ready = not full, combinational from buffer state only.
REQ-012 Latency SHALL be 1 cycle: a beat accepted at edge k into an empty buffer shows out_valid = 1 after edge k.
REQ-013 A beat SHALL be consumed on an edge where out_valid and out_ready are both 1.
REQ-014 result and flag_invalid SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-015 When one entry is held and a push and a pop happen in the same edge, occupancy SHALL stay 1 and the new beat becomes head.
REQ-016 When the buffer is full, in_ready SHALL be 0 and no push occurs; a pop in that cycle frees one slot, so in_ready = 1 after that edge.
REQ-017 When the buffer is empty, out_valid SHALL be 0 and result SHALL hold its last value.
REQ-018 sticky_invalid SHALL set on acceptance of a beat whose invalid = 1 and clear on sticky_clr; when both occur on the same edge, set wins.
REQ-019 Throughput SHALL be one beat per cycle when out_ready is held at 1.

Reset
REQ-020 While rst = 1 at an edge:
- Buffer emptied.
- out_valid = 0, result = 0, flag_invalid = 0, sticky_invalid = 0.
- Inputs ignored.
REQ-021 in_ready SHALL be 0 while rst is asserted and 1 in the first cycle after deassertion.
REQ-022 Reset asserted mid-stream SHALL discard all buffered beats; none are emitted afterwards.

Verification
REQ-023 Sqrt specials (out_ready = 1): in1 = 0x00000000 -> 0x00000000; 0x80000000 -> 0x80000000; 0x7F800000 -> 0x7F800000; 0xFF800000 -> 0x7FFFFFFF with flag_invalid = 1; 0xBF800000 -> 0x7FFFFFFF with flag_invalid = 1; 0x7FC00001 -> 0x7FFFFFFF with flag_invalid = 0.
REQ-024 Square and pass: op = 01, in1 = 0xFF800000 -> 0x7F800000; op = 01, in1 = 0x80000000 -> 0x00000000; op = 10, in1 = 0x40800000 with temp_result = 0x12345678 -> 0x12345678.
REQ-025 Backpressure: out_ready = 0 with 3 back-to-back beats -> 2 accepted, in_ready = 0 from the 3rd cycle, results held stable; then out_ready = 1 -> beats emitted in order, one per cycle.
REQ-026 Sticky: one invalid beat, then sticky_clr pulsed in the same cycle as a second invalid acceptance -> sticky_invalid remains 1; a lone sticky_clr afterwards -> 0.
REQ-027 Reset with 2 beats buffered -> out_valid = 0 the next cycle; in_ready = 1 after deassertion; no stale beat emitted.
REQ-028 Parameter build EXP_W = 11, MAN_W = 52 with op = 00, in1 = 0xBFF0000000000000 -> result = 0x7FFFFFFFFFFFFFFF, flag_invalid = 1.
